// File: rtl/ts_word_unpacker.sv
// ts_word_unpacker
//   Receive-side reassembly of the LSB-first byte stream carrying 32-bit timestamp words
//   {line_id[3:0], ts[27:0]}. Bytes from the UART receiver are collected into words. If the
//   gap between two bytes of one word is too long, the partial word is discarded. Completed
//   words are queued in a small first-word-fall-through FIFO that drives an AXI-Stream master.
//
// Ports
//   clk            : single clock
//   resetn         : synchronous active-low reset
//   rx_dv, rx_byte : received-byte strobe and data
//   clr_status     : pulse, clears overflow and drop_count
//   m_axis_*       : AXI-Stream master (tdata/tvalid/tready)
//   m_line_id      : m_axis_tdata[31:28]
//   m_timestamp    : m_axis_tdata[27:0]
//   frame_err      : 1-cycle pulse when a partial word is discarded on timeout
//   overflow       : sticky flag, a completed word was dropped because the FIFO was full
//   drop_count     : saturating count of dropped words
module ts_word_unpacker #(
  parameter int unsigned TIMEOUT_CYCLES = 2080,
  parameter int unsigned FIFO_DEPTH     = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        rx_dv,
  input  logic [7:0]  rx_byte,
  input  logic        clr_status,
  output logic [31:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic [3:0]  m_line_id,
  output logic [27:0] m_timestamp,
  output logic        frame_err,
  output logic        overflow,
  output logic [15:0] drop_count
);

  localparam int unsigned PtrW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW   = PtrW + 1;
  localparam int unsigned TimerW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TimerW-1:0] TimeoutLast = TimerW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {StB0, StB1, StB2, StB3} state_e;

  state_e              state_q, state_d;
  logic [23:0]         asm_q, asm_d;
  logic [TimerW-1:0]   timer_q, timer_d;
  logic                frame_err_q, frame_err_d;
  logic [31:0]         mem_q [FIFO_DEPTH];
  logic [31:0]         mem_d [FIFO_DEPTH];
  logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]     count_q, count_d;
  logic                overflow_q, overflow_d;
  logic [15:0]         drop_cnt_q, drop_cnt_d;

  logic        push_req;
  logic        timeout;
  logic [31:0] push_word;
  logic        fifo_valid;
  logic        fifo_full;
  logic        pop;
  logic        push_ok;
  logic        drop;

  // State register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= StB0;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. A byte on the timeout cycle takes priority over the timeout.
  always_comb begin
    state_d = state_q;
    if (rx_dv) begin
      unique case (state_q)
        StB0: state_d = StB1;
        StB1: state_d = StB2;
        StB2: state_d = StB3;
        StB3: state_d = StB0;
        default: state_d = StB0;
      endcase
    end else if (timeout) begin
      state_d = StB0;
    end
  end

  // FSM outputs.
  always_comb begin
    push_req = 1'b0;
    timeout  = 1'b0;
    unique case (state_q)
      StB0:       ;
      StB1, StB2: timeout = !rx_dv && (timer_q == TimeoutLast);
      StB3: begin
        push_req = rx_dv;
        timeout  = !rx_dv && (timer_q == TimeoutLast);
      end
      default: ;
    endcase
  end

  assign push_word = {rx_byte, asm_q};

  // Assembly register, inter-byte timer and frame error pulse.
  always_comb begin
    asm_d = asm_q;
    if (timeout) begin
      asm_d = '0;
    end else if (rx_dv) begin
      unique case (state_q)
        StB0: asm_d[7:0]   = rx_byte;
        StB1: asm_d[15:8]  = rx_byte;
        StB2: asm_d[23:16] = rx_byte;
        StB3: ;
        default: ;
      endcase
    end
    timer_d     = (rx_dv || (state_q == StB0)) ? '0 : timer_q + TimerW'(1);
    frame_err_d = timeout;
  end

  // FIFO control. A push into a full FIFO is accepted only when a pop frees a slot
  // in the same cycle.
  assign fifo_valid = (count_q != '0);
  assign fifo_full  = (count_q == CntW'(FIFO_DEPTH));
  assign pop        = fifo_valid && m_axis_tready;
  assign push_ok    = push_req && (!fifo_full || pop);
  assign drop       = push_req && fifo_full && !pop;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_word;
      wr_ptr_d        = wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    unique case ({push_ok, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // Status: the clear is applied first, so a drop in the clear cycle still registers.
  always_comb begin
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (clr_status) begin
      overflow_d = 1'b0;
      drop_cnt_d = '0;
    end
    if (drop) begin
      overflow_d = 1'b1;
      if (drop_cnt_d != 16'hFFFF) begin
        drop_cnt_d = drop_cnt_d + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      asm_q       <= '0;
      timer_q     <= '0;
      frame_err_q <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      drop_cnt_q  <= '0;
    end else begin
      asm_q       <= asm_d;
      timer_q     <= timer_d;
      frame_err_q <= frame_err_d;
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign m_axis_tvalid = fifo_valid;
  assign m_axis_tdata  = fifo_valid ? mem_q[rd_ptr_q] : '0;
  assign m_line_id     = m_axis_tdata[31:28];
  assign m_timestamp   = m_axis_tdata[27:0];
  assign frame_err     = frame_err_q;
  assign overflow      = overflow_q;
  assign drop_count    = drop_cnt_q;

endmodule

// File: tb/tb_ts_word_unpacker.sv
// Directed self-checking bench for ts_word_unpacker.
module tb_ts_word_unpacker;

  logic        clk = 1'b0;
  logic        resetn;
  logic        rx_dv;
  logic [7:0]  rx_byte;
  logic        clr_status;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic [3:0]  m_line_id;
  logic [27:0] m_timestamp;
  logic        frame_err;
  logic        overflow;
  logic [15:0] drop_count;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] words [6];
  logic [31:0] exp_q [4];

  always #5 clk = ~clk;

  ts_word_unpacker #(
    .TIMEOUT_CYCLES(2080),
    .FIFO_DEPTH    (4)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .rx_dv        (rx_dv),
    .rx_byte      (rx_byte),
    .clr_status   (clr_status),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_line_id    (m_line_id),
    .m_timestamp  (m_timestamp),
    .frame_err    (frame_err),
    .overflow     (overflow),
    .drop_count   (drop_count)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_dv   = 1'b1;
    rx_byte = b;
    tick();
    rx_dv   = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input logic clr_last);
    for (int k = 0; k < 4; k++) begin
      if (k == 3) clr_status = clr_last;
      send_byte(w[8*k +: 8]);
    end
    clr_status = 1'b0;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int fe;
    words[0] = 32'h1000_0001;
    words[1] = 32'h2111_1112;
    words[2] = 32'h3222_2223;
    words[3] = 32'h4333_3334;
    words[4] = 32'h5444_4445;
    words[5] = 32'h6555_5556;

    resetn        = 1'b0;
    rx_dv         = 1'b0;
    rx_byte       = '0;
    clr_status    = 1'b0;
    m_axis_tready = 1'b0;
    repeat (3) tick();

    // Reset state
    check_eq("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    check_eq("rst_tdata", m_axis_tdata, 32'd0);
    check_eq("rst_frame_err", 32'(frame_err), 32'd0);
    check_eq("rst_overflow", 32'(overflow), 32'd0);
    check_eq("rst_drop_count", 32'(drop_count), 32'd0);
    resetn = 1'b1;
    tick();

    // Basic word, visible the cycle after the last byte, popped one cycle later
    m_axis_tready = 1'b1;
    send_byte(8'h78);
    send_byte(8'h56);
    send_byte(8'h34);
    check_eq("basic_not_early", 32'(m_axis_tvalid), 32'd0);
    send_byte(8'hA2);
    check_eq("basic_tvalid", 32'(m_axis_tvalid), 32'd1);
    check_eq("basic_tdata", m_axis_tdata, 32'hA234_5678);
    check_eq("basic_line_id", 32'(m_line_id), 32'hA);
    check_eq("basic_ts", 32'(m_timestamp), 32'h0234_5678);
    tick();
    check_eq("basic_popped", 32'(m_axis_tvalid), 32'd0);

    // Timeout discards the partial word
    m_axis_tready = 1'b0;
    send_byte(8'h11);
    send_byte(8'h22);
    fe = 0;
    for (int i = 0; i < 2080; i++) begin
      tick();
      if (frame_err) fe++;
    end
    check_eq("to_pulse_count", 32'(fe), 32'd1);
    check_eq("to_pulse_now", 32'(frame_err), 32'd1);
    send_byte(8'h44);
    check_eq("to_pulse_done", 32'(frame_err), 32'd0);
    send_byte(8'h33);
    send_byte(8'h22);
    send_byte(8'hF1);
    check_eq("to_tvalid", 32'(m_axis_tvalid), 32'd1);
    check_eq("to_tdata", m_axis_tdata, 32'hF122_3344);
    m_axis_tready = 1'b1;
    tick();
    check_eq("to_single", 32'(m_axis_tvalid), 32'd0);

    // Overflow: six words into a four-deep FIFO
    m_axis_tready = 1'b0;
    for (int i = 0; i < 6; i++) send_word(words[i], 1'b0);
    check_eq("ovf_flag", 32'(overflow), 32'd1);
    check_eq("ovf_drop_count", 32'(drop_count), 32'd2);
    check_eq("ovf_head_held", m_axis_tdata, words[0]);
    m_axis_tready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("ovf_drain%0d", i), m_axis_tdata, words[i]);
      check_eq($sformatf("ovf_valid%0d", i), 32'(m_axis_tvalid), 32'd1);
      tick();
    end
    check_eq("ovf_empty", 32'(m_axis_tvalid), 32'd0);
    m_axis_tready = 1'b0;

    // Status clear, then clear coincident with a drop
    clr_status = 1'b1;
    tick();
    clr_status = 1'b0;
    check_eq("clr_overflow", 32'(overflow), 32'd0);
    check_eq("clr_drop_count", 32'(drop_count), 32'd0);
    for (int i = 0; i < 4; i++) send_word(words[i], 1'b0);
    send_word(words[4], 1'b1);
    check_eq("clrdrop_overflow", 32'(overflow), 32'd1);
    check_eq("clrdrop_count", 32'(drop_count), 32'd1);

    // Full FIFO: last byte coincides with a pop, so the word is accepted
    send_byte(8'h42);
    send_byte(8'h00);
    send_byte(8'hDE);
    m_axis_tready = 1'b1;
    send_byte(8'hC0);
    m_axis_tready = 1'b0;
    check_eq("fullpop_drop_count", 32'(drop_count), 32'd1);
    check_eq("fullpop_head", m_axis_tdata, words[1]);
    exp_q[0] = words[1];
    exp_q[1] = words[2];
    exp_q[2] = words[3];
    exp_q[3] = 32'hC0DE_0042;
    m_axis_tready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("fullpop_valid%0d", i), 32'(m_axis_tvalid), 32'd1);
      check_eq($sformatf("fullpop_drain%0d", i), m_axis_tdata, exp_q[i]);
      tick();
    end
    check_eq("fullpop_empty", 32'(m_axis_tvalid), 32'd0);
    m_axis_tready = 1'b0;

    // Reset mid-word with a queued word discards everything
    send_word(words[5], 1'b0);
    check_eq("rst2_queued", 32'(m_axis_tvalid), 32'd1);
    send_byte(8'h01);
    send_byte(8'h02);
    resetn = 1'b0;
    tick();
    check_eq("rst2_tvalid", 32'(m_axis_tvalid), 32'd0);
    check_eq("rst2_tdata", m_axis_tdata, 32'd0);
    check_eq("rst2_overflow", 32'(overflow), 32'd0);
    check_eq("rst2_drop_count", 32'(drop_count), 32'd0);
    check_eq("rst2_frame_err", 32'(frame_err), 32'd0);
    resetn = 1'b1;
    tick();
    send_word(32'h8765_4321, 1'b0);
    check_eq("rst2_word_valid", 32'(m_axis_tvalid), 32'd1);
    check_eq("rst2_word", m_axis_tdata, 32'h8765_4321);
    m_axis_tready = 1'b1;
    tick();
    check_eq("rst2_single", 32'(m_axis_tvalid), 32'd0);
    m_axis_tready = 1'b0;

    // Byte lands exactly on the timeout cycle
    fe = 0;
    send_byte(8'hAB);
    for (int i = 0; i < 2079; i++) begin
      tick();
      if (frame_err) fe++;
    end
    send_byte(8'hEB);
    if (frame_err) fe++;
    send_byte(8'hAF);
    if (frame_err) fe++;
    send_byte(8'h5C);
    if (frame_err) fe++;
    repeat (3) begin
      tick();
      if (frame_err) fe++;
    end
    check_eq("edge_no_frame_err", 32'(fe), 32'd0);
    check_eq("edge_tvalid", 32'(m_axis_tvalid), 32'd1);
    check_eq("edge_tdata", m_axis_tdata, 32'h5CAF_EBAB);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
